// File: rtl/tri_edge_sequencer.sv
// Triangle set-up sequencer: sorts vertices by Y and issues long/short edge jobs to the line engines.
// Optional macro DEGEN_CULL_EN: horizontal triangles are culled and reported on cull_pulse.
module tri_edge_sequencer #(
    parameter int unsigned X_W   = 8,
    parameter int unsigned Y_W   = 8,
    parameter int unsigned Z_W   = 8,
    parameter int unsigned CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   tri_valid,
    output logic                   tri_ready,
    input  logic [Z_W+Y_W+X_W-1:0] tri_p0,
    input  logic [Z_W+Y_W+X_W-1:0] tri_p1,
    input  logic [Z_W+Y_W+X_W-1:0] tri_p2,
    output logic                   job_valid,
    input  logic                   job_ready,
    output logic [Z_W+Y_W+X_W-1:0] job_long_a,
    output logic [Z_W+Y_W+X_W-1:0] job_long_b,
    output logic [Z_W+Y_W+X_W-1:0] job_short_a,
    output logic [Z_W+Y_W+X_W-1:0] job_short_b,
    output logic                   job_cont,
    output logic                   job_last,
    input  logic                   job_done,
    output logic                   busy,
    output logic [CNT_W-1:0]       tri_count
`ifdef DEGEN_CULL_EN
    ,
    output logic                   cull_pulse
`endif
);

    localparam int unsigned PT_W = Z_W + Y_W + X_W;

    typedef logic [PT_W-1:0] pt_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SORT,
        S_ISSUE_TOP,
        S_WAIT_TOP,
        S_ISSUE_BOT,
        S_WAIT_BOT,
        S_DONE
    } state_e;

    state_e state_q, state_d;

    pt_t p0_q, p1_q, p2_q;
    pt_t t_q, m_q, b_q;
    logic two_job_q;
    logic [CNT_W-1:0] count_q;

    logic tri_ready_q, tri_ready_d;
    logic busy_q, busy_d;
    logic job_valid_q, job_valid_d;
    pt_t  job_la_q, job_la_d, job_lb_q, job_lb_d;
    pt_t  job_sa_q, job_sa_d, job_sb_q, job_sb_d;
    logic job_cont_q, job_cont_d;
    logic job_last_q, job_last_d;
`ifdef DEGEN_CULL_EN
    logic cull_pulse_q, cull_pulse_d;
    logic horiz_c;
`endif

    pt_t  srt_t_c, srt_m_c, srt_b_c, swap_c;
    logic two_job_c, flat_top_c, from_sort_c;
    pt_t  src_t_c, src_m_c, src_b_c;
    logic src_two_c;

    function automatic logic [Y_W-1:0] y_of(input pt_t p);
        return p[X_W +: Y_W];
    endfunction

    // Stable three-element bubble network on Y (strict compare keeps input order on ties)
    always_comb begin : sort_net
        swap_c  = '0;
        srt_t_c = p0_q;
        srt_m_c = p1_q;
        srt_b_c = p2_q;
        if (y_of(srt_t_c) > y_of(srt_m_c)) begin
            swap_c = srt_t_c; srt_t_c = srt_m_c; srt_m_c = swap_c;
        end
        if (y_of(srt_m_c) > y_of(srt_b_c)) begin
            swap_c = srt_m_c; srt_m_c = srt_b_c; srt_b_c = swap_c;
        end
        if (y_of(srt_t_c) > y_of(srt_m_c)) begin
            swap_c = srt_t_c; srt_t_c = srt_m_c; srt_m_c = swap_c;
        end
    end

    assign two_job_c  = (y_of(srt_t_c) < y_of(srt_m_c)) && (y_of(srt_m_c) < y_of(srt_b_c));
    assign flat_top_c = (y_of(srt_t_c) == y_of(srt_m_c)) && (y_of(srt_m_c) != y_of(srt_b_c));
`ifdef DEGEN_CULL_EN
    assign horiz_c    = (y_of(srt_t_c) == y_of(srt_b_c));
`endif

    // Leaving SORT the sorted vertices are not registered yet, so take them straight from the network
    assign from_sort_c = (state_q == S_SORT);
    assign src_t_c     = from_sort_c ? srt_t_c   : t_q;
    assign src_m_c     = from_sort_c ? srt_m_c   : m_q;
    assign src_b_c     = from_sort_c ? srt_b_c   : b_q;
    assign src_two_c   = from_sort_c ? two_job_c : two_job_q;

    always_ff @(posedge clk) begin : state_reg
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    always_comb begin : next_state
        state_d = state_q;
        case (state_q)
            S_IDLE:      if (tri_valid) state_d = S_SORT;
            S_SORT: begin
`ifdef DEGEN_CULL_EN
                if (horiz_c)         state_d = S_DONE;
                else if (flat_top_c) state_d = S_ISSUE_BOT;
                else                 state_d = S_ISSUE_TOP;
`else
                if (flat_top_c) state_d = S_ISSUE_BOT;
                else            state_d = S_ISSUE_TOP;
`endif
            end
            S_ISSUE_TOP: if (job_ready) state_d = S_WAIT_TOP;
            S_WAIT_TOP:  if (job_done)  state_d = two_job_q ? S_ISSUE_BOT : S_DONE;
            S_ISSUE_BOT: if (job_ready) state_d = S_WAIT_BOT;
            S_WAIT_BOT:  if (job_done)  state_d = S_DONE;
            S_DONE:      state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state and registered, so they track the state register
    always_comb begin : output_dec
        tri_ready_d = 1'b0;
        busy_d      = 1'b1;
        job_valid_d = 1'b0;
        job_la_d    = job_la_q;
        job_lb_d    = job_lb_q;
        job_sa_d    = job_sa_q;
        job_sb_d    = job_sb_q;
        job_cont_d  = job_cont_q;
        job_last_d  = job_last_q;
`ifdef DEGEN_CULL_EN
        cull_pulse_d = from_sort_c && (state_d == S_DONE);
`endif
        case (state_d)
            S_IDLE: begin
                tri_ready_d = 1'b1;
                busy_d      = 1'b0;
            end
            S_ISSUE_TOP: begin
                job_valid_d = 1'b1;
                job_la_d    = src_t_c;
                job_lb_d    = src_b_c;
                job_sa_d    = src_t_c;
                job_sb_d    = src_m_c;
                job_cont_d  = 1'b0;
                job_last_d  = !src_two_c;
            end
            S_ISSUE_BOT: begin
                job_valid_d = 1'b1;
                job_la_d    = src_t_c;
                job_lb_d    = src_b_c;
                job_sa_d    = src_m_c;
                job_sb_d    = src_b_c;
                job_cont_d  = src_two_c;
                job_last_d  = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin : datapath
        if (!rst) begin
            p0_q        <= '0;
            p1_q        <= '0;
            p2_q        <= '0;
            t_q         <= '0;
            m_q         <= '0;
            b_q         <= '0;
            two_job_q   <= 1'b0;
            count_q     <= '0;
            tri_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            job_valid_q <= 1'b0;
            job_la_q    <= '0;
            job_lb_q    <= '0;
            job_sa_q    <= '0;
            job_sb_q    <= '0;
            job_cont_q  <= 1'b0;
            job_last_q  <= 1'b0;
`ifdef DEGEN_CULL_EN
            cull_pulse_q <= 1'b0;
`endif
        end else begin
            if ((state_q == S_IDLE) && tri_valid) begin
                p0_q <= tri_p0;
                p1_q <= tri_p1;
                p2_q <= tri_p2;
            end
            if (from_sort_c) begin
                t_q       <= srt_t_c;
                m_q       <= srt_m_c;
                b_q       <= srt_b_c;
                two_job_q <= two_job_c;
            end
            if (state_q == S_DONE) count_q <= count_q + CNT_W'(1);
            tri_ready_q <= tri_ready_d;
            busy_q      <= busy_d;
            job_valid_q <= job_valid_d;
            job_la_q    <= job_la_d;
            job_lb_q    <= job_lb_d;
            job_sa_q    <= job_sa_d;
            job_sb_q    <= job_sb_d;
            job_cont_q  <= job_cont_d;
            job_last_q  <= job_last_d;
`ifdef DEGEN_CULL_EN
            cull_pulse_q <= cull_pulse_d;
`endif
        end
    end

    assign tri_ready   = tri_ready_q;
    assign busy        = busy_q;
    assign job_valid   = job_valid_q;
    assign job_long_a  = job_la_q;
    assign job_long_b  = job_lb_q;
    assign job_short_a = job_sa_q;
    assign job_short_b = job_sb_q;
    assign job_cont    = job_cont_q;
    assign job_last    = job_last_q;
    assign tri_count   = count_q;
`ifdef DEGEN_CULL_EN
    assign cull_pulse  = cull_pulse_q;
`endif

endmodule

// File: tb/tb_tri_edge_sequencer.sv
// Randomised self-checking bench for tri_edge_sequencer against a rank-based vertex ordering model.
module tb_tri_edge_sequencer;

    localparam int unsigned X_W   = 8;
    localparam int unsigned Y_W   = 8;
    localparam int unsigned Z_W   = 8;
    localparam int unsigned CNT_W = 4;
    localparam int unsigned PT_W  = Z_W + Y_W + X_W;
    localparam int unsigned CNT_MOD = 1 << CNT_W;

    typedef logic [PT_W-1:0] pt_t;
    typedef struct {
        pt_t la, lb, sa, sb;
        bit  cont, last;
    } job_t;

    logic clk, rst;
    logic tri_valid, tri_ready;
    pt_t  tri_p0, tri_p1, tri_p2;
    logic job_valid, job_ready;
    pt_t  job_long_a, job_long_b, job_short_a, job_short_b;
    logic job_cont, job_last, job_done, busy;
    logic [CNT_W-1:0] tri_count;
`ifdef DEGEN_CULL_EN
    logic cull_pulse;
`endif

    tri_edge_sequencer #(.X_W(X_W), .Y_W(Y_W), .Z_W(Z_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .tri_valid(tri_valid), .tri_ready(tri_ready),
        .tri_p0(tri_p0), .tri_p1(tri_p1), .tri_p2(tri_p2),
        .job_valid(job_valid), .job_ready(job_ready),
        .job_long_a(job_long_a), .job_long_b(job_long_b),
        .job_short_a(job_short_a), .job_short_b(job_short_b),
        .job_cont(job_cont), .job_last(job_last), .job_done(job_done),
        .busy(busy), .tri_count(tri_count)
`ifdef DEGEN_CULL_EN
        , .cull_pulse(cull_pulse)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int unsigned exp_count = 0;
    job_t jq[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic pt_t mk(input int unsigned z, input int unsigned y, input int unsigned x);
        return {Z_W'(z), Y_W'(y), X_W'(x)};
    endfunction

    function automatic logic [Y_W-1:0] yv(input pt_t p);
        return p[X_W +: Y_W];
    endfunction

    // Reference: position of each vertex = count of vertices strictly above it, or level and earlier
    task automatic model(input pt_t p0, input pt_t p1, input pt_t p2, output bit culled);
        pt_t v[3];
        pt_t s[3];
        pt_t t, m, b;
        v = '{p0, p1, p2};
        for (int i = 0; i < 3; i++) begin
            int rank = 0;
            for (int j = 0; j < 3; j++)
                if (yv(v[j]) < yv(v[i]) || (yv(v[j]) == yv(v[i]) && j < i)) rank++;
            s[rank] = v[i];
        end
        t = s[0]; m = s[1]; b = s[2];
        jq.delete();
        culled = 1'b0;
        if (yv(t) == yv(b)) begin
`ifdef DEGEN_CULL_EN
            culled = 1'b1;
`else
            jq.push_back('{la: t, lb: b, sa: t, sb: m, cont: 1'b0, last: 1'b1});
`endif
        end else if (yv(t) == yv(m)) begin
            jq.push_back('{la: t, lb: b, sa: m, sb: b, cont: 1'b0, last: 1'b1});
        end else if (yv(m) == yv(b)) begin
            jq.push_back('{la: t, lb: b, sa: t, sb: m, cont: 1'b0, last: 1'b1});
        end else begin
            jq.push_back('{la: t, lb: b, sa: t, sb: m, cont: 1'b0, last: 1'b0});
            jq.push_back('{la: t, lb: b, sa: m, sb: b, cont: 1'b1, last: 1'b1});
        end
    endtask

    task automatic chk_job(input job_t j);
        chk("job_valid", job_valid, 1);
        chk("job_long_a", job_long_a, j.la);
        chk("job_long_b", job_long_b, j.lb);
        chk("job_short_a", job_short_a, j.sa);
        chk("job_short_b", job_short_b, j.sb);
        chk("job_cont", job_cont, j.cont);
        chk("job_last", job_last, j.last);
        chk("ready_busy", tri_ready, 0);
    endtask

    task automatic run_tri(input pt_t p0, input pt_t p1, input pt_t p2,
                           input int stall, input bit stray, input bit keep_valid);
        bit culled;
        model(p0, p1, p2, culled);
        tri_p0 = p0; tri_p1 = p1; tri_p2 = p2;
        tri_valid = 1'b1;
        chk("ready_idle", tri_ready, 1);
        tick();
        if (!keep_valid) tri_valid = 1'b0;
        tri_p0 = pt_t'($urandom); tri_p1 = pt_t'($urandom); tri_p2 = pt_t'($urandom);
        chk("busy_sort", busy, 1);
        chk("ready_sort", tri_ready, 0);
        chk("valid_sort", job_valid, 0);
        tick();
        if (culled) begin
`ifdef DEGEN_CULL_EN
            chk("cull_pulse", cull_pulse, 1);
`endif
            chk("cull_nojob", job_valid, 0);
        end else begin
            foreach (jq[k]) begin
                for (int s = 0; s < stall; s++) begin
                    chk_job(jq[k]);
                    job_done = stray;
                    tick();
                    job_done = 1'b0;
                end
                chk_job(jq[k]);
                job_ready = 1'b1;
                job_done  = 1'($urandom_range(0, 1));
                tick();
                job_ready = 1'b0;
                job_done  = 1'b0;
                chk("valid_wait", job_valid, 0);
                repeat ($urandom_range(0, 3)) begin
                    job_ready = 1'($urandom_range(0, 1));
                    tick();
                    chk("valid_wait_hold", job_valid, 0);
                end
                job_ready = 1'b0;
                job_done  = 1'b1;
                tick();
                job_done  = 1'b0;
            end
        end
        chk("busy_done", busy, 1);
        chk("valid_done", job_valid, 0);
        tick();
        exp_count = (exp_count + 1) % CNT_MOD;
        chk("tri_count", tri_count, exp_count);
        chk("ready_back", tri_ready, 1);
        chk("busy_idle", busy, 0);
`ifdef DEGEN_CULL_EN
        chk("cull_low", cull_pulse, 0);
`endif
    endtask

    task automatic chk_reset_state();
        chk("rst_ready", tri_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_valid", job_valid, 0);
        chk("rst_count", tri_count, 0);
        chk("rst_long_a", job_long_a, 0);
        chk("rst_short_b", job_short_b, 0);
        chk("rst_cont_last", {job_cont, job_last}, 0);
`ifdef DEGEN_CULL_EN
        chk("rst_cull", cull_pulse, 0);
`endif
    endtask

    function automatic pt_t rnd_pt();
        int unsigned y;
        y = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 3) : $urandom_range(0, 255);
        return mk($urandom_range(0, 255), y, $urandom_range(0, 255));
    endfunction

    initial begin
        rst = 1'b0; tri_valid = 1'b0; job_ready = 1'b0; job_done = 1'b0;
        tri_p0 = '0; tri_p1 = '0; tri_p2 = '0;
        tick(); tick();
        chk_reset_state();
        rst = 1'b1;
        tick();

        run_tri(mk(3, 5, 1), mk(4, 2, 7), mk(9, 9, 0), 0, 1'b0, 1'b0);
        run_tri(mk(1, 4, 2), mk(2, 4, 3), mk(3, 10, 4), 0, 1'b0, 1'b0);
        run_tri(mk(5, 1, 9), mk(6, 6, 8), mk(7, 6, 7), 0, 1'b0, 1'b0);
        run_tri(mk(8, 3, 1), mk(9, 3, 2), mk(10, 3, 3), 0, 1'b0, 1'b0);
        run_tri(mk(3, 5, 1), mk(4, 2, 7), mk(9, 9, 0), 5, 1'b1, 1'b0);

        for (int i = 0; i < 40; i++)
            run_tri(rnd_pt(), rnd_pt(), rnd_pt(), $urandom_range(0, 3),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

        for (int i = 0; i < 6; i++)
            run_tri(rnd_pt(), rnd_pt(), rnd_pt(), 0, 1'b0, 1'b1);
        tri_valid = 1'b0;
        tick();

        // Abort in WAIT_TOP: a late job_done must not resurrect the triangle
        tri_p0 = mk(3, 5, 1); tri_p1 = mk(4, 2, 7); tri_p2 = mk(9, 9, 0);
        tri_valid = 1'b1;
        tick();
        tri_valid = 1'b0;
        tick();
        chk("abort_issue", job_valid, 1);
        job_ready = 1'b1;
        tick();
        job_ready = 1'b0;
        rst = 1'b0;
        tick();
        rst = 1'b1;
        job_done = 1'b1;
        tick();
        job_done = 1'b0;
        exp_count = 0;
        chk_reset_state();
        repeat (3) begin
            tick();
            chk("abort_nojob", job_valid, 0);
        end

        for (int i = 0; i < int'(CNT_MOD); i++)
            run_tri(rnd_pt(), rnd_pt(), rnd_pt(), $urandom_range(0, 2), 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
